// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: operand forwarding, load-use and data-memory
// wait stalls, branch flushes, memory timeout fault and performance counters.
module hazard_ctrl #(
    parameter int TIMEOUT = 15,
    parameter int CNTW    = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [4:0]      Rs1D,
    input  logic [4:0]      Rs2D,
    input  logic [4:0]      Rs1E,
    input  logic [4:0]      Rs2E,
    input  logic [4:0]      RdE,
    input  logic [4:0]      RdM,
    input  logic [4:0]      RdW,
    input  logic            LoadE,
    input  logic            RegWriteM,
    input  logic            RegWriteW,
    input  logic            PCSrcE,
    input  logic            DMemReqM,
    input  logic            DMemReady,
    output logic [1:0]      ForwardAE,
    output logic [1:0]      ForwardBE,
    output logic            StallF,
    output logic            StallD,
    output logic            StallE,
    output logic            StallM,
    output logic            FlushD,
    output logic            FlushE,
    output logic            FlushW,
    output logic            MemFault,
    output logic [CNTW-1:0] StallCount,
    output logic [CNTW-1:0] FlushCount
);

    localparam int WCW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [WCW-1:0]  TIMEOUT_W = WCW'(TIMEOUT);
    localparam logic [WCW-1:0]  WCNT_ONE  = WCW'(1'b1);
    localparam logic [CNTW-1:0] CNT_ONE   = CNTW'(1'b1);
    localparam logic [CNTW-1:0] CNT_MAX   = {CNTW{1'b1}};

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_WAIT  = 2'd1,
        ST_FAULT = 2'd2
    } state_t;

    state_t          state_r;
    state_t          state_nx_s;
    logic [WCW-1:0]  wait_cnt_r;
    logic [WCW-1:0]  wait_cnt_nx_s;
    logic            mem_fault_r;
    logic [CNTW-1:0] stall_count_r;
    logic [CNTW-1:0] flush_count_r;
    logic            lw_stall_s;
    logic            mem_stall_s;

    // Memory stage has priority because it holds the youngest result.
    function automatic logic [1:0] fwd_sel(input logic [4:0] rs, input logic [4:0] rdm,
                                           input logic [4:0] rdw, input logic rwm,
                                           input logic rww);
        logic [1:0] sel;
        if ((rs != 5'd0) && (rs == rdm) && rwm) begin
            sel = 2'b10;
        end else if ((rs != 5'd0) && (rs == rdw) && rww) begin
            sel = 2'b01;
        end else begin
            sel = 2'b00;
        end
        return sel;
    endfunction

    // FSM state and wait-cycle counter register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= ST_RUN;
            wait_cnt_r <= {WCW{1'b0}};
        end else begin
            state_r    <= state_nx_s;
            wait_cnt_r <= wait_cnt_nx_s;
        end
    end

    // FSM next-state logic; FAULT is only left through reset
    always_comb begin
        state_nx_s    = state_r;
        wait_cnt_nx_s = wait_cnt_r;
        case (state_r)
            ST_RUN: begin
                if (DMemReqM && !DMemReady) begin
                    state_nx_s    = ST_WAIT;
                    wait_cnt_nx_s = WCNT_ONE;
                end else begin
                    state_nx_s    = ST_RUN;
                    wait_cnt_nx_s = {WCW{1'b0}};
                end
            end
            ST_WAIT: begin
                if (DMemReady) begin
                    state_nx_s    = ST_RUN;
                    wait_cnt_nx_s = {WCW{1'b0}};
                end else if (wait_cnt_r == TIMEOUT_W) begin
                    state_nx_s    = ST_FAULT;
                    wait_cnt_nx_s = wait_cnt_r;
                end else begin
                    state_nx_s    = ST_WAIT;
                    wait_cnt_nx_s = wait_cnt_r + WCNT_ONE;
                end
            end
            ST_FAULT: begin
                state_nx_s    = ST_FAULT;
                wait_cnt_nx_s = wait_cnt_r;
            end
            default: begin
                state_nx_s    = ST_RUN;
                wait_cnt_nx_s = {WCW{1'b0}};
            end
        endcase
    end

    // FSM outputs: stall, flush and forwarding controls, all zero-latency
    always_comb begin
        lw_stall_s  = LoadE && (RdE != 5'd0) && ((Rs1D == RdE) || (Rs2D == RdE));
        mem_stall_s = (DMemReqM && !DMemReady) || (state_r == ST_FAULT);
        ForwardAE   = fwd_sel(Rs1E, RdM, RdW, RegWriteM, RegWriteW);
        ForwardBE   = fwd_sel(Rs2E, RdM, RdW, RegWriteM, RegWriteW);
        StallM      = mem_stall_s;
        StallE      = mem_stall_s;
        StallF      = mem_stall_s || lw_stall_s;
        StallD      = mem_stall_s || lw_stall_s;
        FlushW      = mem_stall_s;
        // A frozen Execute stage must keep its instruction; the flush waits for release.
        FlushD      = PCSrcE && !mem_stall_s;
        FlushE      = (PCSrcE || lw_stall_s) && !mem_stall_s;
    end

    // Sticky fault flag and saturating stall/flush performance counters
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_fault_r   <= 1'b0;
            stall_count_r <= {CNTW{1'b0}};
            flush_count_r <= {CNTW{1'b0}};
        end else begin
            mem_fault_r <= (state_nx_s == ST_FAULT);
            if (StallF && (stall_count_r != CNT_MAX)) begin
                stall_count_r <= stall_count_r + CNT_ONE;
            end else begin
                stall_count_r <= stall_count_r;
            end
            if (FlushE && (flush_count_r != CNT_MAX)) begin
                flush_count_r <= flush_count_r + CNT_ONE;
            end else begin
                flush_count_r <= flush_count_r;
            end
        end
    end

    assign MemFault   = mem_fault_r;
    assign StallCount = stall_count_r;
    assign FlushCount = flush_count_r;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: expectations are queued as each cycle's
// stimulus is driven and popped once the DUT outputs have settled.
module tb_hazard_ctrl;

    logic        clk;
    logic        reset;
    logic [4:0]  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic        LoadE, RegWriteM, RegWriteW, PCSrcE, DMemReqM, DMemReady;
    logic [1:0]  ForwardAE, ForwardBE;
    logic        StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, MemFault;
    logic [31:0] StallCount, FlushCount;

    // {ForwardAE, ForwardBE, StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, MemFault}
    typedef struct packed {
        logic [13:0] sig;
        logic [31:0] sc;
        logic [31:0] fc;
    } exp_t;

    exp_t        sb[$];
    logic [13:0] obs_sig;
    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_sc = 32'd0;
    logic [31:0] exp_fc = 32'd0;

    hazard_ctrl #(.TIMEOUT(15), .CNTW(32)) dut (
        .clk(clk), .reset(reset),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .RdM(RdM), .RdW(RdW),
        .LoadE(LoadE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .PCSrcE(PCSrcE),
        .DMemReqM(DMemReqM), .DMemReady(DMemReady),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
        .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW), .MemFault(MemFault),
        .StallCount(StallCount), .FlushCount(FlushCount)
    );

    assign obs_sig = {ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
                      FlushD, FlushE, FlushW, MemFault};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive_idle();
        Rs1D = 5'd0; Rs2D = 5'd0; Rs1E = 5'd0; Rs2E = 5'd0; RdE = 5'd0; RdM = 5'd0; RdW = 5'd0;
        LoadE = 1'b0; RegWriteM = 1'b0; RegWriteW = 1'b0; PCSrcE = 1'b0;
        DMemReqM = 1'b0; DMemReady = 1'b0;
    endtask

    // Counters shown this cycle are the ones accumulated by earlier edges.
    task automatic push_exp(input logic [1:0] fa, input logic [1:0] fb, input logic [3:0] stall,
                            input logic [2:0] flush, input logic mf);
        exp_t e;
        e.sig = {fa, fb, stall, flush, mf};
        e.sc  = exp_sc;
        e.fc  = exp_fc;
        sb.push_back(e);
        exp_sc = exp_sc + {31'd0, stall[3]};
        exp_fc = exp_fc + {31'd0, flush[1]};
    endtask

    task automatic test_reset();
        exp_t e;
        reset = 1'b1;
        drive_idle();
        @(negedge clk);
        exp_sc = 32'd0; exp_fc = 32'd0;
        push_exp(2'b00, 2'b00, 4'b0000, 3'b000, 1'b0);
        #1;
        e = sb.pop_front();
        checks++; if (obs_sig !== e.sig) begin errors++; $display("FAIL reset outputs: got %b expected %b", obs_sig, e.sig); end
        checks++; if (StallCount !== e.sc) begin errors++; $display("FAIL reset StallCount: got %0d expected %0d", StallCount, e.sc); end
        checks++; if (FlushCount !== e.fc) begin errors++; $display("FAIL reset FlushCount: got %0d expected %0d", FlushCount, e.fc); end
        reset = 1'b0;
    endtask

    task automatic test_forward();
        exp_t e;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            drive_idle();
            case (i)
                0: begin Rs1E = 5'd5; RdM = 5'd5; RegWriteM = 1'b1; RdW = 5'd5; RegWriteW = 1'b1;
                         push_exp(2'b10, 2'b00, 4'b0000, 3'b000, 1'b0); end
                1: begin Rs1E = 5'd5; RdM = 5'd5; RegWriteM = 1'b0; RdW = 5'd5; RegWriteW = 1'b1;
                         push_exp(2'b01, 2'b00, 4'b0000, 3'b000, 1'b0); end
                2: begin Rs1E = 5'd0; RdM = 5'd0; RegWriteM = 1'b1; RdW = 5'd0; RegWriteW = 1'b1;
                         push_exp(2'b00, 2'b00, 4'b0000, 3'b000, 1'b0); end
                3: begin Rs1E = 5'd3; Rs2E = 5'd9; RdM = 5'd3; RegWriteM = 1'b1; RdW = 5'd9; RegWriteW = 1'b1;
                         push_exp(2'b10, 2'b01, 4'b0000, 3'b000, 1'b0); end
                default: begin Rs1E = 5'd4; Rs2E = 5'd9; RdM = 5'd9; RegWriteM = 1'b1; RdW = 5'd4; RegWriteW = 1'b0;
                         push_exp(2'b00, 2'b10, 4'b0000, 3'b000, 1'b0); end
            endcase
            #1;
            e = sb.pop_front();
            checks++; if (obs_sig !== e.sig) begin errors++; $display("FAIL forward[%0d] outputs: got %b expected %b", i, obs_sig, e.sig); end
            checks++; if (StallCount !== e.sc) begin errors++; $display("FAIL forward[%0d] StallCount: got %0d expected %0d", i, StallCount, e.sc); end
            checks++; if (FlushCount !== e.fc) begin errors++; $display("FAIL forward[%0d] FlushCount: got %0d expected %0d", i, FlushCount, e.fc); end
        end
    endtask

    task automatic test_load_use();
        exp_t e;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            drive_idle();
            case (i)
                0: begin LoadE = 1'b1; RdE = 5'd7; Rs2D = 5'd7;
                         push_exp(2'b00, 2'b00, 4'b1100, 3'b010, 1'b0); end
                2: begin LoadE = 1'b1; RdE = 5'd0; Rs1D = 5'd0;
                         push_exp(2'b00, 2'b00, 4'b0000, 3'b000, 1'b0); end
                3: begin LoadE = 1'b1; RdE = 5'd4; Rs1D = 5'd4; PCSrcE = 1'b1;
                         push_exp(2'b00, 2'b00, 4'b1100, 3'b110, 1'b0); end
                4: begin PCSrcE = 1'b1;
                         push_exp(2'b00, 2'b00, 4'b0000, 3'b110, 1'b0); end
                default: push_exp(2'b00, 2'b00, 4'b0000, 3'b000, 1'b0);
            endcase
            #1;
            e = sb.pop_front();
            checks++; if (obs_sig !== e.sig) begin errors++; $display("FAIL load_use[%0d] outputs: got %b expected %b", i, obs_sig, e.sig); end
            checks++; if (StallCount !== e.sc) begin errors++; $display("FAIL load_use[%0d] StallCount: got %0d expected %0d", i, StallCount, e.sc); end
            checks++; if (FlushCount !== e.fc) begin errors++; $display("FAIL load_use[%0d] FlushCount: got %0d expected %0d", i, FlushCount, e.fc); end
        end
    endtask

    task automatic test_mem_wait();
        exp_t e;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            drive_idle();
            case (i)
                0, 1, 2, 5: begin DMemReqM = 1'b1; DMemReady = 1'b0;
                         push_exp(2'b00, 2'b00, 4'b1111, 3'b001, 1'b0); end
                3, 6: begin DMemReqM = 1'b1; DMemReady = 1'b1;
                         push_exp(2'b00, 2'b00, 4'b0000, 3'b000, 1'b0); end
                default: push_exp(2'b00, 2'b00, 4'b0000, 3'b000, 1'b0);
            endcase
            #1;
            e = sb.pop_front();
            checks++; if (obs_sig !== e.sig) begin errors++; $display("FAIL mem_wait[%0d] outputs: got %b expected %b", i, obs_sig, e.sig); end
            checks++; if (StallCount !== e.sc) begin errors++; $display("FAIL mem_wait[%0d] StallCount: got %0d expected %0d", i, StallCount, e.sc); end
            checks++; if (FlushCount !== e.fc) begin errors++; $display("FAIL mem_wait[%0d] FlushCount: got %0d expected %0d", i, FlushCount, e.fc); end
        end
    endtask

    task automatic test_branch_under_stall();
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            drive_idle();
            case (i)
                0, 1: begin PCSrcE = 1'b1; DMemReqM = 1'b1; DMemReady = 1'b0;
                         push_exp(2'b00, 2'b00, 4'b1111, 3'b001, 1'b0); end
                2: begin PCSrcE = 1'b1; DMemReqM = 1'b1; DMemReady = 1'b1;
                         push_exp(2'b00, 2'b00, 4'b0000, 3'b110, 1'b0); end
                default: push_exp(2'b00, 2'b00, 4'b0000, 3'b000, 1'b0);
            endcase
            #1;
            e = sb.pop_front();
            checks++; if (obs_sig !== e.sig) begin errors++; $display("FAIL branch_stall[%0d] outputs: got %b expected %b", i, obs_sig, e.sig); end
            checks++; if (StallCount !== e.sc) begin errors++; $display("FAIL branch_stall[%0d] StallCount: got %0d expected %0d", i, StallCount, e.sc); end
            checks++; if (FlushCount !== e.fc) begin errors++; $display("FAIL branch_stall[%0d] FlushCount: got %0d expected %0d", i, FlushCount, e.fc); end
        end
    endtask

    task automatic test_timeout();
        exp_t e;
        for (int i = 0; i < 22; i++) begin
            @(negedge clk);
            drive_idle();
            if (i < 16) begin
                DMemReqM = 1'b1; DMemReady = 1'b0;
                push_exp(2'b00, 2'b00, 4'b1111, 3'b001, 1'b0);
            end else if (i < 18) begin
                DMemReqM = 1'b1; DMemReady = 1'b0;
                push_exp(2'b00, 2'b00, 4'b1111, 3'b001, 1'b1);
            end else if (i < 21) begin
                DMemReqM = 1'b1; DMemReady = 1'b1; PCSrcE = 1'b1;
                push_exp(2'b00, 2'b00, 4'b1111, 3'b001, 1'b1);
            end else begin
                Rs1E = 5'd2; RdM = 5'd2; RegWriteM = 1'b1;
                push_exp(2'b10, 2'b00, 4'b1111, 3'b001, 1'b1);
            end
            #1;
            e = sb.pop_front();
            checks++; if (obs_sig !== e.sig) begin errors++; $display("FAIL timeout[%0d] outputs: got %b expected %b", i, obs_sig, e.sig); end
            checks++; if (StallCount !== e.sc) begin errors++; $display("FAIL timeout[%0d] StallCount: got %0d expected %0d", i, StallCount, e.sc); end
            checks++; if (FlushCount !== e.fc) begin errors++; $display("FAIL timeout[%0d] FlushCount: got %0d expected %0d", i, FlushCount, e.fc); end
        end
    endtask

    task automatic test_reset_in_fault();
        exp_t e;
        @(negedge clk);
        drive_idle();
        reset = 1'b1;
        exp_sc = 32'd0; exp_fc = 32'd0;
        push_exp(2'b00, 2'b00, 4'b0000, 3'b000, 1'b0);
        #1;
        e = sb.pop_front();
        checks++; if (obs_sig !== e.sig) begin errors++; $display("FAIL reset_fault outputs: got %b expected %b", obs_sig, e.sig); end
        checks++; if (StallCount !== e.sc) begin errors++; $display("FAIL reset_fault StallCount: got %0d expected %0d", StallCount, e.sc); end
        checks++; if (FlushCount !== e.fc) begin errors++; $display("FAIL reset_fault FlushCount: got %0d expected %0d", FlushCount, e.fc); end
        @(posedge clk);
        #2;
        reset = 1'b0;
    endtask

    task automatic test_resume();
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            drive_idle();
            case (i)
                0: begin LoadE = 1'b1; RdE = 5'd12; Rs1D = 5'd12;
                         push_exp(2'b00, 2'b00, 4'b1100, 3'b010, 1'b0); end
                1: begin DMemReqM = 1'b1; DMemReady = 1'b0;
                         push_exp(2'b00, 2'b00, 4'b1111, 3'b001, 1'b0); end
                default: push_exp(2'b00, 2'b00, 4'b0000, 3'b000, 1'b0);
            endcase
            #1;
            e = sb.pop_front();
            checks++; if (obs_sig !== e.sig) begin errors++; $display("FAIL resume[%0d] outputs: got %b expected %b", i, obs_sig, e.sig); end
            checks++; if (StallCount !== e.sc) begin errors++; $display("FAIL resume[%0d] StallCount: got %0d expected %0d", i, StallCount, e.sc); end
            checks++; if (FlushCount !== e.fc) begin errors++; $display("FAIL resume[%0d] FlushCount: got %0d expected %0d", i, FlushCount, e.fc); end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_forward();
        test_load_use();
        test_mem_wait();
        test_branch_under_stall();
        test_timeout();
        test_reset_in_fault();
        test_resume();
        checks++;
        if (sb.size() !== 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d entries expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 15, the maximum number of consecutive data-memory wait cycles before a fault is raised.
REQ-002 SHALL have parameter CNTW, default 32, the width of the performance counters.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on posedge clk.
REQ-004 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have ports Rs1D, Rs2D, input, 5 each, the source registers in Decode.
REQ-006 SHALL have ports Rs1E, Rs2E, RdE, input, 5 each, the sources and destination in Execute.
REQ-007 SHALL have ports RdM and RdW, input, 5 each, the destinations in Memory and Writeback.
REQ-008 SHALL have port LoadE, input, 1, indicating that Execute holds a load.
REQ-009 SHALL have ports RegWriteM and RegWriteW, input, 1 each, the register-write enables in Memory and Writeback.
REQ-010 SHALL have port PCSrcE, input, 1, indicating a taken branch or jump resolved in Execute.
REQ-011 SHALL have port DMemReqM, input, 1, indicating a data-memory access in Memory.
REQ-012 SHALL have port DMemReady, input, 1, indicating that the data memory completes the access this cycle.
REQ-013 SHALL have ports ForwardAE and ForwardBE, output, 2 each, the ALU operand forwarding selects.
REQ-014 SHALL have ports StallF, StallD, StallE, StallM, output, 1 each, which drive the pipeline-register enables (enable = ~Stall).
REQ-015 SHALL have ports FlushD, FlushE, FlushW, output, 1 each, which drive the pipeline-register synchronous clears.
REQ-016 SHALL have port MemFault, output, 1, a sticky timeout error flag.
REQ-017 SHALL have ports StallCount and FlushCount, output, CNTW each, the performance counters.

Function
REQ-018 SHALL drive ForwardAE to 2'b10 when Rs1E!=0, Rs1E==RdM and RegWriteM; otherwise to 2'b01 when Rs1E!=0, Rs1E==RdW and RegWriteW; otherwise to 2'b00; Memory takes priority; ForwardBE follows the same rules with Rs2E.
REQ-019 SHALL compute lwStall = LoadE & RdE!=0 & (Rs1D==RdE | Rs2D==RdE), combinationally.
REQ-020 SHALL implement the FSM states RUN, WAIT and FAULT with a wait counter of width ceil(log2(TIMEOUT+1)).
REQ-021 SHALL, in RUN, move to WAIT with the counter set to 1 when DMemReqM & ~DMemReady, and otherwise stay in RUN.
REQ-022 SHALL, in WAIT, move to RUN with the counter cleared when DMemReady=1, move to FAULT when the counter equals TIMEOUT and DMemReady=0, and otherwise increment the counter.
REQ-023 SHALL make FAULT absorbing until reset and hold MemFault=1 while in FAULT.
REQ-024 SHALL compute memStall = (DMemReqM & ~DMemReady) | (state==FAULT), combinationally.
REQ-025 SHALL drive StallM = StallE = memStall.
REQ-026 SHALL drive StallF = StallD = memStall | lwStall.
REQ-027 SHALL drive FlushW = memStall, inserting a bubble into Writeback while Memory is frozen.
REQ-028 SHALL drive FlushD = PCSrcE & ~memStall.
REQ-029 SHALL drive FlushE = (PCSrcE | lwStall) & ~memStall, so that a frozen Execute instruction is never cleared; a branch held in Execute during a memory stall flushes on the first cycle the stall releases.
REQ-030 SHALL, when lwStall and PCSrcE are both set without memStall, assert StallF, StallD, FlushD and FlushE together, with the flush discarding the stalled instruction.
REQ-031 SHALL increment StallCount in each cycle that StallF=1, saturating at all-ones.
REQ-032 SHALL increment FlushCount in each cycle that FlushE=1, saturating at all-ones.
REQ-033 SHALL drive the outputs combinationally from the current inputs and state, with zero added latency, except for MemFault and the counters, which are registered.

Reset
REQ-034 SHALL, on reset assertion, immediately and asynchronously force state=RUN, wait counter=0, MemFault=0, StallCount=0 and FlushCount=0, including when reset occurs mid-WAIT or in FAULT.
REQ-035 SHALL, during reset with all inputs 0, drive every output to 0.
REQ-036 SHALL resume normal operation on the first posedge clk after reset deasserts.

Verification
REQ-037 SHALL cover forwarding: Rs1E=5, RdM=5, RegWriteM=1, RdW=5, RegWriteW=1 -> ForwardAE=10; with RegWriteM=0 -> ForwardAE=01; with Rs1E=0 -> ForwardAE=00.
REQ-038 SHALL cover load-use: LoadE=1, RdE=7, Rs2D=7 -> StallF=StallD=FlushE=1 for 1 cycle, StallCount+1, FlushCount+1.
REQ-039 SHALL cover memory wait: DMemReqM=1 with DMemReady low for 3 cycles then high -> StallF/D/E/M=1 and FlushW=1 for 3 cycles, FSM returns to RUN, StallCount+3.
REQ-040 SHALL cover branch under stall: PCSrcE=1 during a 2-cycle memory wait -> FlushD=FlushE=0 during the wait, then =1 on the release cycle.
REQ-041 SHALL cover timeout: TIMEOUT=15 with DMemReady held low -> MemFault=1 after 16 wait cycles, all Stall outputs stuck at 1, and a later DMemReady=1 has no effect.
REQ-042 SHALL cover reset in FAULT: assert reset mid-clock -> MemFault, the counters and the stalls return to 0 immediately, without waiting for a clock edge.
